// File: rtl/spi_reg_bridge.sv
// Frame decoder between the SPI slave byte receiver and a byte-wide register bank.
// Write frames fill registers from an auto-incrementing pointer; read frames stream them back.
module spi_reg_bridge #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                    ico_clk,
    input  logic                    rst,
    input  logic                    sel_active,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    output logic [7:0]              tx_byte,
    output logic                    tx_load,
    output logic                    wr_strobe,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic [7:0]              err_count
);

    localparam logic [2:0] WAIT_IDLE = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] CMD       = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] READ      = 3'd4;
    localparam logic [2:0] DISCARD   = 3'd5;

    // 8-bit copy of the bank size so the range check has matching widths (128 fits).
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [7:0]        regs_reg [NUM_REGS];
    logic [7:0]        tx_byte_reg;
    logic              tx_load_reg;
    logic              wr_strobe_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        err_count_reg;

    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_bad;

    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_bad  = ({1'b0, rx_byte[6:0]} >= NUM_REGS_B);

    always_ff @(posedge ico_clk) begin
        if (rst) begin
            state_reg     <= WAIT_IDLE;
            ptr_reg       <= '0;
            tx_byte_reg   <= 8'h00;
            tx_load_reg   <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            err_count_reg <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= 8'h00;
            end
        end else begin
            tx_load_reg   <= 1'b0;
            wr_strobe_reg <= 1'b0;
            case (state_reg)
                WAIT_IDLE: begin
                    // A frame already running at reset release is skipped entirely.
                    if (!sel_active) begin
                        state_reg <= IDLE;
                    end
                end
                IDLE: begin
                    if (sel_active) begin
                        state_reg <= CMD;
                    end
                end
                default: begin
                    if (!sel_active) begin
                        state_reg <= IDLE;
                    end else if (rx_valid) begin
                        case (state_reg)
                            CMD: begin
                                if (cmd_bad) begin
                                    state_reg <= DISCARD;
                                    if (err_count_reg != 8'hFF) begin
                                        err_count_reg <= err_count_reg + 8'd1;
                                    end
                                end else if (rx_byte[7]) begin
                                    state_reg   <= READ;
                                    tx_byte_reg <= regs_reg[cmd_addr];
                                    tx_load_reg <= 1'b1;
                                    ptr_reg     <= cmd_addr + 1'b1;
                                end else begin
                                    state_reg <= WRITE;
                                    ptr_reg   <= cmd_addr;
                                end
                            end
                            WRITE: begin
                                regs_reg[ptr_reg] <= rx_byte;
                                wr_strobe_reg     <= 1'b1;
                                wr_addr_reg       <= ptr_reg;
                                ptr_reg           <= ptr_reg + 1'b1;
                            end
                            READ: begin
                                tx_byte_reg <= regs_reg[ptr_reg];
                                tx_load_reg <= 1'b1;
                                ptr_reg     <= ptr_reg + 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    assign tx_byte   = tx_byte_reg;
    assign tx_load   = tx_load_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomized and directed frames against a frame-level reference model of the bridge.
module tb_spi_reg_bridge;

    localparam int NR = 8;
    localparam int AW = 3;

    logic            ico_clk = 1'b0;
    logic            rst = 1'b1;
    logic            sel_active = 1'b0;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic [7:0]      tx_byte;
    logic            tx_load;
    logic            wr_strobe;
    logic [AW-1:0]   wr_addr;
    logic [NR*8-1:0] regs_flat;
    logic [7:0]      err_count;

    spi_reg_bridge #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
        .ico_clk    (ico_clk),
        .rst        (rst),
        .sel_active (sel_active),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .tx_load    (tx_load),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .regs_flat  (regs_flat),
        .err_count  (err_count)
    );

    always #5 ico_clk = ~ico_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame phases of the reference model.
    localparam int P_WAIT = 0, P_IDLE = 1, P_CMD = 2, P_WR = 3, P_RD = 4, P_DIS = 5;

    int         m_phase;
    int         m_ptr;
    int         m_err;
    logic [7:0] m_tx;
    logic [7:0] m_regs [NR];
    int         m_wraddr;
    logic [7:0] fbytes [$];

    // One clock cycle: apply inputs at the falling edge, advance the model, check after the rising edge.
    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] b);
        logic            e_load;
        logic            e_wr;
        logic [NR*8-1:0] e_flat;
        int              a;
        rst = r; sel_active = s; rx_valid = v; rx_byte = b;
        e_load = 1'b0; e_wr = 1'b0;
        if (r) begin
            m_phase = P_WAIT; m_ptr = 0; m_err = 0; m_tx = 8'h00; m_wraddr = 0;
            for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        end else if (m_phase == P_WAIT) begin
            if (!s) m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (s) m_phase = P_CMD;
        end else if (!s) begin
            m_phase = P_IDLE;
        end else if (v) begin
            if (m_phase == P_CMD) begin
                a = int'(b) % 128;
                if (a >= NR) begin
                    m_phase = P_DIS;
                    if (m_err < 255) m_err++;
                end else if (b >= 8'h80) begin
                    m_phase = P_RD; m_tx = m_regs[a]; e_load = 1'b1; m_ptr = (a + 1) % NR;
                end else begin
                    m_phase = P_WR; m_ptr = a;
                end
            end else if (m_phase == P_WR) begin
                m_regs[m_ptr] = b; e_wr = 1'b1; m_wraddr = m_ptr; m_ptr = (m_ptr + 1) % NR;
            end else if (m_phase == P_RD) begin
                m_tx = m_regs[m_ptr]; e_load = 1'b1; m_ptr = (m_ptr + 1) % NR;
            end
        end
        for (int i = 0; i < NR; i++) e_flat[8*i +: 8] = m_regs[i];
        @(posedge ico_clk);
        #1;
        check("tx_load", 64'(tx_load), 64'(e_load));
        check("wr_strobe", 64'(wr_strobe), 64'(e_wr));
        if (e_wr) check("wr_addr", 64'(wr_addr), 64'(m_wraddr));
        check("tx_byte", 64'(tx_byte), 64'(m_tx));
        check("regs_flat", 64'(regs_flat), 64'(e_flat));
        check("err_count", 64'(err_count), 64'(m_err));
        @(negedge ico_clk);
    endtask

    // Sends fbytes as one frame; abort_at drops sel_active together with that byte.
    task automatic frame(input int abort_at, input int gap_max);
        bit aborted = 0;
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < fbytes.size() && !aborted; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) step(0, 1, 0, 8'($urandom));
            end
            if (i == abort_at) begin
                step(0, 0, 1, fbytes[i]);
                aborted = 1;
            end else begin
                step(0, 1, 1, fbytes[i]);
            end
        end
        step(0, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] keep_r1;
        int         len;
        @(negedge ico_clk);
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check("reset_regs", 64'(regs_flat), 64'h0);
        check("reset_tx", 64'(tx_byte), 64'h0);
        step(0, 0, 0, 8'h00);

        fbytes = '{8'h02, 8'h11, 8'h22, 8'h33};
        frame(-1, 0);
        check("reg2", 64'(regs_flat[23:16]), 64'h11);
        check("reg3", 64'(regs_flat[31:24]), 64'h22);
        check("reg4", 64'(regs_flat[39:32]), 64'h33);

        fbytes = '{8'h07, 8'hAA, 8'hBB};
        frame(-1, 0);
        check("reg7_wrap", 64'(regs_flat[63:56]), 64'hAA);
        check("reg0_wrap", 64'(regs_flat[7:0]), 64'hBB);

        fbytes = '{8'h83, 8'h5A, 8'hA5};
        frame(-1, 0);

        for (int k = 0; k < 300; k++) begin
            fbytes = '{8'h10, 8'h55};
            frame(-1, 0);
        end
        check("err_sat", 64'(err_count), 64'd255);

        keep_r1 = m_regs[1];
        fbytes = '{8'h00, 8'h01, 8'h02};
        frame(2, 0);
        check("abort_reg0", 64'(regs_flat[7:0]), 64'h01);
        check("abort_reg1", 64'(regs_flat[15:8]), 64'(keep_r1));

        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(0, 1, 1, 8'h05);
        step(0, 1, 1, 8'h9C);
        step(0, 0, 0, 8'h00);
        fbytes = '{8'h05, 8'h9C};
        frame(-1, 0);
        check("reg5_after_rst", 64'(regs_flat[47:40]), 64'h9C);

        for (int k = 0; k < 200; k++) begin
            len = $urandom_range(0, 10);
            fbytes = {};
            fbytes.push_back({1'($urandom), 7'($urandom_range(0, 11))});
            for (int j = 0; j < len; j++) fbytes.push_back(8'($urandom));
            frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1,
                  ($urandom_range(0, 1) == 0) ? 0 : 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
